uart_tx_fifo_reader: RTL and testbench

Serial transmitter that drains the team's synchronous FIFO from its read side. It pops one word at a time using the FIFO's `rd`/`empty`/`r_data` interface, which has first-word-fall-through read data. Each word goes out as an asynchronous serial frame: one start bit, DBIT data bits LSB-first, then a stop period. It sits between the TX FIFO and the serial pin, and generates its baud timing internally from the system clock using 16x oversampling ticks.

---
 rtl/uart_tx_fifo_reader.sv | 148 ++++++++++++++
 tb/tb_uart_tx_fifo_reader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_reader.sv
// Serial UART transmitter that drains a first-word-fall-through FIFO.
// Frames are start bit, DBIT data bits LSB-first, then SB_TICK oversample ticks of stop.
module uart_tx_fifo_reader #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 163,
    parameter int DVSR_W  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tx_en,
    input  logic            fifo_empty,
    input  logic [DBIT-1:0] fifo_r_data,
    output logic            fifo_rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int TICK_MAX = (SB_TICK > 16) ? SB_TICK : 16;
    localparam int TICK_W   = $clog2(TICK_MAX + 1);
    localparam int BIT_W    = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [DVSR_W-1:0] BAUD_LAST      = DVSR_W'(DVSR - 1);
    localparam logic [TICK_W-1:0] BIT_TICK_LAST  = TICK_W'(15);
    localparam logic [TICK_W-1:0] STOP_TICK_LAST = TICK_W'(SB_TICK - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT       = BIT_W'(DBIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state, state_next;
    logic [DVSR_W-1:0] baud_cnt, baud_next;
    logic [TICK_W-1:0] tick_cnt, tick_next;
    logic [BIT_W-1:0]  bit_idx, bit_next;
    logic [DBIT-1:0]   shift_reg, shift_next;
    logic              tx_reg, tx_next;
    logic              done_reg, done_next;
    logic              s_tick;

    // The baud counter only runs inside a frame, so every bit starts on a fresh count.
    assign s_tick       = (baud_cnt == BAUD_LAST) && (state != IDLE);
    assign fifo_rd      = (state == IDLE) && tx_en && !fifo_empty && !reset;
    assign tx           = tx_reg;
    assign tx_busy      = (state != IDLE);
    assign tx_done_tick = done_reg;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
            done_reg  <= 1'b0;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            tick_cnt  <= tick_next;
            bit_idx   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
            done_reg  <= done_next;
        end
    end

    // NOTE: every output of this block is given a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        tick_next  = tick_cnt;
        bit_next   = bit_idx;
        shift_next = shift_reg;
        tx_next    = tx_reg;
        done_next  = 1'b0;

        if (state == IDLE) begin
            baud_next = '0;
        end else begin
            baud_next = (baud_cnt == BAUD_LAST) ? '0 : baud_cnt + DVSR_W'(1);
        end

        unique case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (fifo_rd) begin
                    shift_next = fifo_r_data;
                    state_next = START;
                    tx_next    = 1'b0;
                    tick_next  = '0;
                end
            end

            START: begin
                if (s_tick) begin
                    if (tick_cnt == BIT_TICK_LAST) begin
                        state_next = DATA;
                        tick_next  = '0;
                        bit_next   = '0;
                        tx_next    = shift_reg[0];
                    end else begin
                        tick_next = tick_cnt + TICK_W'(1);
                    end
                end
            end

            DATA: begin
                if (s_tick) begin
                    if (tick_cnt == BIT_TICK_LAST) begin
                        tick_next  = '0;
                        shift_next = shift_reg >> 1;
                        if (bit_idx == LAST_BIT) begin
                            state_next = STOP;
                            tx_next    = 1'b1;
                        end else begin
                            bit_next = bit_idx + BIT_W'(1);
                            tx_next  = shift_next[0];
                        end
                    end else begin
                        tick_next = tick_cnt + TICK_W'(1);
                    end
                end
            end

            STOP: begin
                tx_next = 1'b1;
                if (s_tick) begin
                    if (tick_cnt == STOP_TICK_LAST) begin
                        state_next = IDLE;
                        tick_next  = '0;
                        done_next  = 1'b1;
                    end else begin
                        tick_next = tick_cnt + TICK_W'(1);
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Bench for uart_tx_fifo_reader: two parameterisations driven from a FIFO model,
// every clock compared against a waveform built from word values and frame arithmetic.
module tb_uart_tx_fifo_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       sel;
    logic       tx_en;
    logic       fifo_empty;
    logic [7:0] fifo_r_data;

    logic rd_a, tx_a, busy_a, done_a;
    logic rd_b, tx_b, busy_b, done_b;

    always #5 clk = ~clk;

    uart_tx_fifo_reader #(.DBIT(8), .SB_TICK(16), .DVSR(4), .DVSR_W(4)) dut_a (
        .clk          (clk),
        .reset        (reset),
        .tx_en        (tx_en & ~sel),
        .fifo_empty   (fifo_empty),
        .fifo_r_data  (fifo_r_data),
        .fifo_rd      (rd_a),
        .tx           (tx_a),
        .tx_busy      (busy_a),
        .tx_done_tick (done_a)
    );

    uart_tx_fifo_reader #(.DBIT(7), .SB_TICK(32), .DVSR(2), .DVSR_W(4)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .tx_en        (tx_en & sel),
        .fifo_empty   (fifo_empty),
        .fifo_r_data  (fifo_r_data[6:0]),
        .fifo_rd      (rd_b),
        .tx           (tx_b),
        .tx_busy      (busy_b),
        .tx_done_tick (done_b)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;

    int dvsr, dbit, sbt;
    logic [7:0] fifo_q[$];
    bit         exp_q[$];
    bit         done_due = 1'b0;
    int         pop_cyc[$];
    int         done_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic int frame_len();
        return (16 * (1 + dbit) + sbt) * dvsr;
    endfunction

    // Expected line levels for one frame, one entry per clock.
    function automatic void push_frame(input logic [7:0] w);
        for (int i = 0; i < 16 * dvsr; i++) exp_q.push_back(1'b0);
        for (int b = 0; b < dbit; b++)
            for (int i = 0; i < 16 * dvsr; i++) exp_q.push_back(w[b]);
        for (int i = 0; i < sbt * dvsr; i++) exp_q.push_back(1'b1);
    endfunction

    function automatic void update_fifo();
        fifo_empty  = (fifo_q.size() == 0);
        fifo_r_data = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
    endfunction

    task automatic cycle();
        logic s_rd, s_tx, s_busy, s_done;
        bit   idle, exp_rd, pop_now;
        @(negedge clk);
        s_rd   = sel ? rd_b   : rd_a;
        s_tx   = sel ? tx_b   : tx_a;
        s_busy = sel ? busy_b : busy_a;
        s_done = sel ? done_b : done_a;
        idle   = (exp_q.size() == 0);
        check("tx", s_tx, idle ? 1'b1 : exp_q[0]);
        check("tx_busy", s_busy, !idle);
        check("tx_done_tick", s_done, done_due);
        if (s_done) done_cyc.push_back(cyc);
        exp_rd = idle && tx_en && !fifo_empty && !reset;
        check("fifo_rd", s_rd, exp_rd);
        if (!idle) void'(exp_q.pop_front());
        done_due = !idle && (exp_q.size() == 0);
        pop_now  = 1'b0;
        if (exp_rd) begin
            push_frame(fifo_q[0]);
            pop_now = 1'b1;
            pop_cyc.push_back(cyc);
        end
        if (reset) begin
            exp_q.delete();
            done_due = 1'b0;
        end
        @(posedge clk);
        #1;
        if (pop_now) void'(fifo_q.pop_front());
        update_fifo();
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic new_phase();
        pop_cyc.delete();
        done_cyc.delete();
    endtask

    initial begin
        sel   = 1'b0;
        reset = 1'b1;
        tx_en = 1'b0;
        dvsr  = 4;
        dbit  = 8;
        sbt   = 16;
        update_fifo();

        // Reset, then an empty FIFO with tx_en high.
        run(3);
        reset = 1'b0;
        tx_en = 1'b1;
        new_phase();
        run(200);
        check("idle_pops", pop_cyc.size(), 0);
        check("idle_dones", done_cyc.size(), 0);

        // Single frame of 8'hA5.
        new_phase();
        fifo_q.push_back(8'hA5);
        update_fifo();
        run(700);
        check("single_pops", pop_cyc.size(), 1);
        check("single_dones", done_cyc.size(), 1);
        if (pop_cyc.size() == 1 && done_cyc.size() == 1)
            check("single_len", done_cyc[0] - pop_cyc[0], frame_len() + 1);

        // Back-to-back words.
        new_phase();
        fifo_q.push_back(8'h3C);
        fifo_q.push_back(8'hFF);
        update_fifo();
        run(1400);
        check("b2b_pops", pop_cyc.size(), 2);
        check("b2b_dones", done_cyc.size(), 2);
        if (pop_cyc.size() == 2 && done_cyc.size() == 2) begin
            check("b2b_spacing", pop_cyc[1] - pop_cyc[0], frame_len() + 1);
            check("b2b_pop_on_done", pop_cyc[1], done_cyc[0]);
        end

        // Gating with tx_en, then dropping it mid-DATA.
        new_phase();
        tx_en = 1'b0;
        fifo_q.push_back(8'($urandom));
        fifo_q.push_back(8'($urandom));
        update_fifo();
        run(100);
        check("gate_no_pop", pop_cyc.size(), 0);
        tx_en = 1'b1;
        run(1);
        check("gate_pop_same_cycle", pop_cyc.size(), 1);
        run(64 + 3 * 64);
        tx_en = 1'b0;
        run(600);
        check("gate_frame_done", done_cyc.size(), 1);
        check("gate_no_second_pop", pop_cyc.size(), 1);
        tx_en = 1'b1;
        run(700);
        check("gate_resume_pops", pop_cyc.size(), 2);

        // Random words with tx_en toggling.
        new_phase();
        for (int i = 0; i < 6; i++) fifo_q.push_back(8'($urandom));
        update_fifo();
        for (int i = 0; i < 5000; i++) begin
            tx_en = ($urandom_range(0, 3) != 0);
            cycle();
        end
        tx_en = 1'b1;
        run(1400);
        check("rand_pops", pop_cyc.size(), 6);
        check("rand_dones", done_cyc.size(), 6);

        // Reset during bit 3 of 8'h00, next frame follows cleanly.
        new_phase();
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'($urandom));
        update_fifo();
        run(1 + 64 + 3 * 64 + 20);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        run(700);
        check("rst_pops", pop_cyc.size(), 2);
        check("rst_dones", done_cyc.size(), 1);
        if (pop_cyc.size() == 2 && done_cyc.size() == 1)
            check("rst_next_len", done_cyc[0] - pop_cyc[1], frame_len() + 1);

        // Reset suppresses a pop even with data waiting.
        new_phase();
        reset = 1'b1;
        fifo_q.push_back(8'($urandom));
        update_fifo();
        run(2);
        check("rst_blocks_pop", pop_cyc.size(), 0);
        reset = 1'b0;
        run(700);
        check("rst_release_pop", pop_cyc.size(), 1);

        // Second parameterisation: DBIT=7, SB_TICK=32, DVSR=2.
        sel  = 1'b1;
        dvsr = 2;
        dbit = 7;
        sbt  = 32;
        new_phase();
        fifo_q.push_back(8'h55);
        update_fifo();
        run(400);
        check("b_pops", pop_cyc.size(), 1);
        check("b_dones", done_cyc.size(), 1);
        if (pop_cyc.size() == 1 && done_cyc.size() == 1)
            check("b_len", done_cyc[0] - pop_cyc[0], 321);
        new_phase();
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'($urandom_range(0, 127)));
        update_fifo();
        for (int i = 0; i < 1600; i++) begin
            tx_en = ($urandom_range(0, 3) != 0);
            cycle();
        end
        tx_en = 1'b1;
        run(700);
        check("b_rand_pops", pop_cyc.size(), 4);
        check("b_rand_dones", done_cyc.size(), 4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
